ldpe_bank_ctrl: RTL and testbench
=================================

# ldpe_bank_ctrl

Sequencing controller that shares one bank of NWORDS gated latch words (LDPE-style D/G/GE/PRE cells) between NREQ synchronous requesters. It arbitrates write requests round-robin, then drives the shared data bus, the per-word gate and the global gate enable with programmable setup, pulse and hold phases, so the latches never see D change while G is high. It also sequences a bulk preset of all words. It sits between the clocked register-file front end and the latch bank.

## Interface
- NREQ, 2, number of requesters (≥1)
- NWORDS, 8, number of latch words in the bank
- AW, 3, address width; NWORDS ≤ 2**AW
- DW, 8, latch word width
- SETUP, 1, cycles D/GE are stable before gate rises (≥1)
- PULSE, 2, cycles gate (or preset) is held high (≥1)
- HOLD, 1, cycles D/GE are held after gate falls (≥1)

- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ  in  NREQ  write request per requester; held until its DONE
- ADDR  in  NREQ*AW  word address, slice i for requester i
- WDATA  in  NREQ*DW  write data, slice i for requester i
- PRESET_REQ  in  1  bulk preset request; held until PRESET_DONE
- DONE  out  NREQ  one-cycle completion pulse per requester
- ERR  out  1  one-cycle pulse with DONE when the address was ≥ NWORDS
- PRESET_DONE  out  1  one-cycle preset completion pulse
- BUSY  out  1  high in any state other than IDLE
- LD  out  DW  shared latch data bus
- LG  out  NWORDS  per-word gate, at most one bit high
- LGE  out  1  global gate enable
- LPRE  out  1  bulk preset to all words

## Operation
- States: IDLE, SETUP, GATE, HOLD, PRESET, PHOLD.
- Reset: state IDLE, all outputs 0, round-robin pointer 0, captured address/data 0.
- IDLE: the block evaluates requests in this order.
  - If PRESET_REQ is high, go to PRESET. Preset has priority over all writes.
  - Otherwise, if any unmasked REQ is high, the round-robin arbiter picks the winner: the first requester at or after the pointer. The block captures the winner's ADDR and WDATA and goes to SETUP.
  - A requester whose DONE is high in the current cycle is masked from arbitration that cycle.
- SETUP for SETUP cycles: LD = captured data, LGE = 1, LG = 0.
- GATE for PULSE cycles: LD and LGE unchanged, LG[addr] = 1. If addr ≥ NWORDS, no LG bit is set.
- HOLD for HOLD cycles: LG = 0, LD and LGE unchanged.
- Return to IDLE:
  - DONE[winner] = 1 for that first IDLE cycle, and ERR = 1 if addr ≥ NWORDS.
  - The pointer becomes winner+1 mod NREQ.
  - LGE = 0. LD keeps its value until the next capture.
- PRESET for PULSE cycles: LPRE = 1, LG = 0, LGE = 0.
- PHOLD for HOLD cycles: LPRE = 0. Then return to IDLE with PRESET_DONE = 1 for one cycle. The pointer is unchanged.
- REQ changes and PRESET_REQ during a transaction are ignored until the block is back in IDLE. Transactions are never aborted.
- Reset mid-operation: every output drops to 0 asynchronously and no DONE is issued. Requesters must re-issue their requests.
- Phase counter width is $clog2(max(SETUP,PULSE,HOLD)+1). The counter reloads on every state entry.

## Timing
- All outputs are registered. Nothing combinational runs from inputs to outputs.
- Write latency, measured from the IDLE edge that accepts REQ to the DONE pulse, is SETUP+PULSE+HOLD+1 cycles (5 at defaults).
- Preset latency, from acceptance to PRESET_DONE, is PULSE+HOLD+1 cycles (4 at defaults).
- Minimum spacing between accepts is one IDLE cycle. Back-to-back throughput is one write per SETUP+PULSE+HOLD+1 cycles.
- LD and LGE are constant from the first SETUP cycle through the last HOLD cycle.
- LG is never high in the same cycle as LPRE.

## Structure
- Package ldpe_ctrl_pkg holds:
  - the state enum
  - the phase-counter width function
  - the parameter-legality checks: SETUP/PULSE/HOLD ≥ 1 and NWORDS ≤ 2**AW, checked at elaboration
- One sub-module, rr_arbiter (NREQ): inputs are the request vector, mask and pointer; output is the one-hot grant. It is purely combinational. The pointer register stays in ldpe_bank_ctrl.

## Test plan
- Single write, defaults: REQ[0]=1, ADDR0=5, WDATA0=8'hA5.
  - LGE and LD=A5 are high for cycles 1–4.
  - LG=8'b0010_0000 in cycles 2–3.
  - DONE[0] pulses in cycle 5.
- Contention: REQ=2'b11 held continuously, pointer 0.
  - Grants go 0, 1, 0, 1, with DONEs 5 cycles apart.
  - A requester never wins in the same cycle as its own DONE.
- Preset priority: PRESET_REQ and REQ[1] are raised together in IDLE.
  - LPRE is high for 2 cycles, then PRESET_DONE.
  - The REQ[1] write follows immediately after.
- Out-of-range address with NWORDS=6: write to ADDR=7.
  - LG stays 0 throughout.
  - DONE and ERR pulse together in cycle 5.
- Reset mid-GATE: assert RST_N=0 during cycle 2 of a write.
  - LG, LGE, LD and BUSY go to 0 immediately.
  - No DONE is issued after release.
  - A re-issued request completes normally.

Source files
------------

// File: rtl/ldpe_bank_ctrl_pkg.sv
// Shared types and elaboration helpers for the LDPE latch-bank controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, phase-counter width function, parameter legality check.
package ldpe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_GATE   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_PRESET = 3'd4,
    ST_PHOLD  = 3'd5
  } state_t;

  // Wide enough to hold the longest phase length.
  function automatic int unsigned phase_cnt_w(input int unsigned setup_c,
                                              input int unsigned pulse_c,
                                              input int unsigned hold_c);
    int unsigned m;
    m = setup_c;
    if (pulse_c > m) m = pulse_c;
    if (hold_c > m) m = hold_c;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int nreq, input int nwords, input int aw,
                                   input int setup_c, input int pulse_c, input int hold_c);
    return (nreq >= 1) && (nwords >= 1) && (aw >= 1) && (aw < 31) &&
           (nwords <= (1 << aw)) &&
           (setup_c >= 1) && (pulse_c >= 1) && (hold_c >= 1);
  endfunction

endpackage

// File: rtl/ldpe_bank_ctrl_if.sv
// Bundle of requester-side and latch-bank-side signals of ldpe_bank_ctrl.
// Latency: n/a (wires only).
// Backpressure: requests are level-held until their done pulse.
//
// master: requesters + latch bank view; slave: the controller.
interface ldpe_bank_ctrl_if #(
  parameter int NREQ   = 2,
  parameter int NWORDS = 8,
  parameter int AW     = 3,
  parameter int DW     = 8
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic               preset_req;
  logic [NREQ-1:0]    done;
  logic               err;
  logic               preset_done;
  logic               busy;
  logic [DW-1:0]      ld;
  logic [NWORDS-1:0]  lg;
  logic               lge;
  logic               lpre;

  modport master (
    output req, addr, wdata, preset_req,
    input  done, err, preset_done, busy, ld, lg, lge, lpre
  );

  modport slave (
    input  req, addr, wdata, preset_req,
    output done, err, preset_done, busy, ld, lg, lge, lpre
  );

endinterface

// File: rtl/ldpe_bank_ctrl_arb.sv
// Combinational round-robin arbiter: first unmasked requester at or after ptr wins.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; grant is all-zero when no eligible request.
//
// Ports: req/mask (NREQ) in, ptr (PW) in, grant (NREQ, one-hot or zero) out.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] elig;
  assign elig = req & ~mask;

  // Scan from the farthest offset back to the pointer so the last hit,
  // i.e. the one closest to the pointer, is the one that sticks.
  always_comb begin
    int idx;
    grant = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (elig[idx]) grant = NREQ'(1) << idx;
    end
  end

endmodule

// File: rtl/ldpe_bank_ctrl.sv
// Shares one bank of gated latch words between NREQ writers with setup/pulse/hold sequencing.
// Latency: write done SETUP+PULSE+HOLD+1 cycles after accept; preset done PULSE+HOLD+1.
// Backpressure: req/preset_req held until done; accepts only in IDLE, never aborts.
//
// Ports: clk, rst_n (async active-low); bus (slave): req/addr/wdata/preset_req in,
//        done/err/preset_done/busy and latch drives ld/lg/lge/lpre out (all registered).
module ldpe_bank_ctrl
  import ldpe_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int NWORDS = 8,
  parameter int AW     = 3,
  parameter int DW     = 8,
  parameter int SETUP  = 1,
  parameter int PULSE  = 2,
  parameter int HOLD   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ldpe_bank_ctrl_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = phase_cnt_w(SETUP, PULSE, HOLD);

  if (!params_ok(NREQ, NWORDS, AW, SETUP, PULSE, HOLD)) begin : g_bad_params
    $error("ldpe_bank_ctrl: illegal parameter set");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              pdone_q, pdone_d;
  logic              busy_q, busy_d;
  logic [NWORDS-1:0] lg_q, lg_d;
  logic              lge_q, lge_d;
  logic              lpre_q, lpre_d;

  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     gnt_idx;
  logic [AW-1:0]     gnt_addr;
  logic [DW-1:0]     gnt_data;
  logic              addr_ok;

  // A requester still holding req in its own done cycle must not win again.
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (bus.req),
    .mask  (done_q),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx  = PW'(i);
        gnt_addr = bus.addr[i*AW +: AW];
        gnt_data = bus.wdata[i*DW +: DW];
      end
    end
  end

  assign addr_ok = ({1'b0, addr_q} < (AW+1)'(NWORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = '0;
    err_d   = 1'b0;
    pdone_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A preset finishing this cycle is not restarted by its own held request.
        if (bus.preset_req && !pdone_q) begin
          state_d = ST_PRESET;
          cnt_d   = CW'(PULSE - 1);
        end else if (|grant) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP - 1);
          win_d   = gnt_idx;
          addr_d  = gnt_addr;
          data_d  = gnt_data;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_GATE;
          cnt_d   = CW'(PULSE - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = NREQ'(1) << win_q;
          err_d   = !addr_ok;
          ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PRESET: begin
        if (cnt_q == '0) begin
          state_d = ST_PHOLD;
          cnt_d   = CW'(HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PHOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pdone_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Latch drives are decoded from the next state so they come straight off flops.
    // GATE is only entered from SETUP, so addr_q already holds the captured address.
    lg_d = '0;
    if (state_d == ST_GATE && addr_ok) lg_d = NWORDS'(1) << addr_q;
    lge_d  = (state_d == ST_SETUP) || (state_d == ST_GATE) || (state_d == ST_HOLD);
    lpre_d = (state_d == ST_PRESET);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      pdone_q <= 1'b0;
      busy_q  <= 1'b0;
      lg_q    <= '0;
      lge_q   <= 1'b0;
      lpre_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pdone_q <= pdone_d;
      busy_q  <= busy_d;
      lg_q    <= lg_d;
      lge_q   <= lge_d;
      lpre_q  <= lpre_d;
    end
  end

  // The captured data register is the latch data bus: it holds until the next capture.
  assign bus.ld          = data_q;
  assign bus.lg          = lg_q;
  assign bus.lge         = lge_q;
  assign bus.lpre        = lpre_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.preset_done = pdone_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ldpe_bank_ctrl.sv
// Directed self-checking bench for ldpe_bank_ctrl (default bank plus a 6-word bank).
// Latency: checks sampled 1 time unit after each rising clock edge.
// Backpressure: requests are held until the expected done cycle, then dropped.
module tb_ldpe_bank_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ldpe_bank_ctrl_if #(.NREQ(2), .NWORDS(8), .AW(3), .DW(8)) b8 ();
  ldpe_bank_ctrl_if #(.NREQ(2), .NWORDS(6), .AW(3), .DW(8)) b6 ();

  ldpe_bank_ctrl #(.NREQ(2), .NWORDS(8), .AW(3), .DW(8), .SETUP(1), .PULSE(2), .HOLD(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  ldpe_bank_ctrl #(.NREQ(2), .NWORDS(6), .AW(3), .DW(8), .SETUP(1), .PULSE(2), .HOLD(1)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b6)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ca[2];
    int cd[2];
    int w;
    logic [1:0] saw_done;

    ca[0] = 2;     ca[1] = 4;
    cd[0] = 'h11;  cd[1] = 'h22;

    rst_n = 1'b0;
    b8.req = '0; b8.addr = '0; b8.wdata = '0; b8.preset_req = 1'b0;
    b6.req = '0; b6.addr = '0; b6.wdata = '0; b6.preset_req = 1'b0;
    tick(2);

    // Reset state
    chk("rst_busy", 32'(b8.busy), 32'd0);
    chk("rst_lg",   32'(b8.lg),   32'd0);
    chk("rst_ld",   32'(b8.ld),   32'd0);
    chk("rst_lge",  32'(b8.lge),  32'd0);
    chk("rst_lpre", 32'(b8.lpre), 32'd0);
    chk("rst_done", 32'(b8.done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(b8.busy), 32'd0);

    // Single write: requester 0, addr 5, data A5
    b8.addr  = {3'd0, 3'd5};
    b8.wdata = {8'h00, 8'hA5};
    b8.req   = 2'b01;
    tick();
    chk("w1_c1_lge",  32'(b8.lge),  32'd1);
    chk("w1_c1_ld",   32'(b8.ld),   32'hA5);
    chk("w1_c1_lg",   32'(b8.lg),   32'd0);
    chk("w1_c1_busy", 32'(b8.busy), 32'd1);
    tick();
    chk("w1_c2_lg",   32'(b8.lg),   32'h20);
    chk("w1_c2_lge",  32'(b8.lge),  32'd1);
    tick();
    chk("w1_c3_lg",   32'(b8.lg),   32'h20);
    chk("w1_c3_ld",   32'(b8.ld),   32'hA5);
    tick();
    chk("w1_c4_lg",   32'(b8.lg),   32'd0);
    chk("w1_c4_lge",  32'(b8.lge),  32'd1);
    chk("w1_c4_done", 32'(b8.done), 32'd0);
    tick();
    chk("w1_c5_done", 32'(b8.done), 32'b01);
    chk("w1_c5_err",  32'(b8.err),  32'd0);
    chk("w1_c5_lge",  32'(b8.lge),  32'd0);
    chk("w1_c5_busy", 32'(b8.busy), 32'd0);
    chk("w1_c5_ld",   32'(b8.ld),   32'hA5);
    b8.req = 2'b00;
    tick();
    chk("w1_c6_done", 32'(b8.done), 32'd0);

    // Pointer back to 0 before contention
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Contention: both held, grants alternate 0,1,0,1
    b8.addr  = {3'd4, 3'd2};
    b8.wdata = {8'h22, 8'h11};
    b8.req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      tick();
      chk("cont_ld",   32'(b8.ld),   32'(cd[w]));
      chk("cont_nodn", 32'(b8.done), 32'd0);
      tick();
      chk("cont_lg",   32'(b8.lg),   32'(1 << ca[w]));
      tick(2);
      tick();
      chk("cont_done", 32'(b8.done), 32'(1 << w));
    end
    b8.req = 2'b00;
    tick();
    chk("cont_idle", 32'(b8.busy), 32'd0);

    // Preset wins over a simultaneous write, write follows immediately
    b8.addr       = {3'd3, 3'd0};
    b8.wdata      = {8'h5A, 8'h00};
    b8.preset_req = 1'b1;
    b8.req        = 2'b10;
    tick();
    chk("pre_c1_lpre", 32'(b8.lpre), 32'd1);
    chk("pre_c1_lge",  32'(b8.lge),  32'd0);
    chk("pre_c1_lg",   32'(b8.lg),   32'd0);
    chk("pre_c1_ld",   32'(b8.ld),   32'h22);
    chk("pre_c1_busy", 32'(b8.busy), 32'd1);
    tick();
    chk("pre_c2_lpre", 32'(b8.lpre), 32'd1);
    tick();
    chk("pre_c3_lpre", 32'(b8.lpre), 32'd0);
    chk("pre_c3_pdn",  32'(b8.preset_done), 32'd0);
    tick();
    chk("pre_c4_pdn",  32'(b8.preset_done), 32'd1);
    chk("pre_c4_busy", 32'(b8.busy), 32'd0);
    b8.preset_req = 1'b0;
    tick();
    chk("pw_c5_ld",  32'(b8.ld),  32'h5A);
    chk("pw_c5_lge", 32'(b8.lge), 32'd1);
    chk("pw_c5_pdn", 32'(b8.preset_done), 32'd0);
    tick();
    chk("pw_c6_lg",  32'(b8.lg),  32'h08);
    tick(2);
    tick();
    chk("pw_c9_done", 32'(b8.done), 32'b10);
    b8.req = 2'b00;
    tick();

    // Out-of-range address on the 6-word bank
    b6.addr  = {3'd0, 3'd7};
    b6.wdata = {8'h00, 8'h3C};
    b6.req   = 2'b01;
    tick();
    chk("oor_c1_ld", 32'(b6.ld), 32'h3C);
    chk("oor_c1_lg", 32'(b6.lg), 32'd0);
    tick();
    chk("oor_c2_lg",  32'(b6.lg),  32'd0);
    chk("oor_c2_lge", 32'(b6.lge), 32'd1);
    tick();
    chk("oor_c3_lg", 32'(b6.lg), 32'd0);
    tick();
    chk("oor_c4_lg", 32'(b6.lg), 32'd0);
    tick();
    chk("oor_c5_done", 32'(b6.done), 32'b01);
    chk("oor_c5_err",  32'(b6.err),  32'd1);
    b6.req = 2'b00;
    tick();
    chk("oor_c6_err", 32'(b6.err), 32'd0);

    // Reset during GATE
    b8.addr  = {3'd0, 3'd1};
    b8.wdata = {8'h00, 8'h77};
    b8.req   = 2'b01;
    tick(2);
    chk("rg_c2_lg", 32'(b8.lg), 32'h02);
    #2;
    rst_n  = 1'b0;
    b8.req = 2'b00;
    #1;
    chk("rg_lg",   32'(b8.lg),   32'd0);
    chk("rg_lge",  32'(b8.lge),  32'd0);
    chk("rg_ld",   32'(b8.ld),   32'd0);
    chk("rg_busy", 32'(b8.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    saw_done = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick();
      saw_done = saw_done | b8.done;
    end
    chk("rg_no_done", 32'(saw_done), 32'd0);
    chk("rg_idle",    32'(b8.busy),  32'd0);
    b8.req = 2'b01;
    tick();
    chk("rr_c1_ld", 32'(b8.ld), 32'h77);
    tick();
    chk("rr_c2_lg", 32'(b8.lg), 32'h02);
    tick(2);
    tick();
    chk("rr_c5_done", 32'(b8.done), 32'b01);
    b8.req = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
